// File: rtl/traffic_light_sequencer_pkg.sv
// Shared constants for the intersection controller:
// state encodings, lamp codes and direction codes.
package traffic_light_sequencer_pkg;

    localparam logic [2:0] NS_GREEN  = 3'd0;
    localparam logic [2:0] NS_YELLOW = 3'd1;
    localparam logic [2:0] ALLRED    = 3'd2;
    localparam logic [2:0] EW_GREEN  = 3'd3;
    localparam logic [2:0] EW_YELLOW = 3'd4;
    localparam logic [2:0] PED_WALK  = 3'd5;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    localparam logic NS = 1'b0;
    localparam logic EW = 1'b1;

endpackage

// File: rtl/traffic_light_sequencer_phase_timer.sv
// Loadable phase down-counter; load wins over tick,
// and the count holds at zero until reloaded.
module traffic_light_sequencer_phase_timer #(
    parameter int                   TIMER_W = 4,
    parameter logic [TIMER_W-1:0]   RST_VAL = '0
) (
    input  logic               clk_in,
    input  logic               rst_n,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    input  logic               tick,
    output logic               zero
);

    logic [TIMER_W-1:0] count_q;

    // Reload on phase entry, otherwise count ticks down to zero.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= RST_VAL;
        end else if (load) begin
            count_q <= load_val;
        end else if (tick && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/traffic_light_sequencer.sv
// Four-way intersection Moore FSM with pedestrian WALK phase.
// Phases are counted in 1 Hz ticks from the shared phase timer.
module traffic_light_sequencer
    import traffic_light_sequencer_pkg::*;
#(
    parameter int GREEN_SEC  = 10,
    parameter int YELLOW_SEC = 5,
    parameter int ALLRED_SEC = 1,
    parameter int WALK_SEC   = 5,
    parameter int TIMER_W    = 4
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       tick_in,
    input  logic       ped_req_in,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       walk_out,
    output logic       ped_ack_out,
    output logic [2:0] state_out
);

    // A zero length is treated as a one-tick phase.
    localparam logic [TIMER_W-1:0] G_LD =
        TIMER_W'((GREEN_SEC > 1) ? GREEN_SEC - 1 : 0);
    localparam logic [TIMER_W-1:0] Y_LD =
        TIMER_W'((YELLOW_SEC > 1) ? YELLOW_SEC - 1 : 0);
    localparam logic [TIMER_W-1:0] R_LD =
        TIMER_W'((ALLRED_SEC > 1) ? ALLRED_SEC - 1 : 0);
    localparam logic [TIMER_W-1:0] W_LD =
        TIMER_W'((WALK_SEC > 1) ? WALK_SEC - 1 : 0);

    logic [2:0]         state_q;
    logic [2:0]         state_d;
    logic               dir_q;
    logic               dir_d;
    logic               ped_pending_q;
    logic               ped_ack_q;
    logic               zero;
    logic               advance;
    logic               enter_walk;
    logic               load;
    logic [TIMER_W-1:0] load_val;

    assign advance    = tick_in && zero;
    assign enter_walk = (state_d == PED_WALK) && (state_q != PED_WALK);
    assign load       = (state_d != state_q);

    // Next-state: phases only move on a tick with the timer expired.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        case (state_q)
            NS_GREEN:  if (advance) state_d = NS_YELLOW;
            NS_YELLOW: if (advance) begin
                state_d = ALLRED;
                dir_d   = EW;
            end
            EW_GREEN:  if (advance) state_d = EW_YELLOW;
            EW_YELLOW: if (advance) begin
                state_d = ALLRED;
                dir_d   = NS;
            end
            ALLRED:    if (advance) begin
                if (ped_pending_q)
                    state_d = PED_WALK;
                else
                    state_d = (dir_q == EW) ? EW_GREEN : NS_GREEN;
            end
            PED_WALK:  if (advance)
                state_d = (dir_q == EW) ? EW_GREEN : NS_GREEN;
            default:   state_d = ALLRED;
        endcase
    end

    // Length of the phase being entered, minus one.
    always_comb begin
        load_val = R_LD;
        case (state_d)
            NS_GREEN, EW_GREEN:   load_val = G_LD;
            NS_YELLOW, EW_YELLOW: load_val = Y_LD;
            PED_WALK:             load_val = W_LD;
            default:              load_val = R_LD;
        endcase
    end

    // State, direction, pending request and entry-acknowledge registers.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ALLRED;
            dir_q         <= NS;
            ped_pending_q <= 1'b0;
            ped_ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            ped_ack_q <= enter_walk;
            if (enter_walk)
                ped_pending_q <= 1'b0;
            else if (ped_req_in && (state_q != PED_WALK))
                ped_pending_q <= 1'b1;
        end
    end

    traffic_light_sequencer_phase_timer #(
        .TIMER_W (TIMER_W),
        .RST_VAL (R_LD)
    ) u_phase_timer (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (load_val),
        .tick     (tick_in),
        .zero     (zero)
    );

    // Moore lamp decode; illegal codes show red on both roads.
    always_comb begin
        ns_light = RED;
        ew_light = RED;
        walk_out = 1'b0;
        case (state_q)
            NS_GREEN:  ns_light = GRN;
            NS_YELLOW: ns_light = YEL;
            EW_GREEN:  ew_light = GRN;
            EW_YELLOW: ew_light = YEL;
            PED_WALK:  walk_out = 1'b1;
            default:   ;
        endcase
    end

    assign ped_ack_out = ped_ack_q;
    assign state_out   = state_q;

endmodule

// File: tb/tb_traffic_light_sequencer.sv
// Directed bench for traffic_light_sequencer: phase sequence,
// pedestrian handling, slow ticks, reset and illegal-state recovery.
module tb_traffic_light_sequencer;

    localparam logic [2:0] S_NSG = 3'd0;
    localparam logic [2:0] S_NSY = 3'd1;
    localparam logic [2:0] S_AR  = 3'd2;
    localparam logic [2:0] S_EWG = 3'd3;
    localparam logic [2:0] S_EWY = 3'd4;
    localparam logic [2:0] S_PED = 3'd5;

    logic       clk_in = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_in = 1'b0;
    logic       ped_req_in = 1'b0;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic       walk_out;
    logic       ped_ack_out;
    logic [2:0] state_out;

    int n_checks = 0;
    int n_fail = 0;
    bit running = 1'b0;

    traffic_light_sequencer dut (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .tick_in     (tick_in),
        .ped_req_in  (ped_req_in),
        .ns_light    (ns_light),
        .ew_light    (ew_light),
        .walk_out    (walk_out),
        .ped_ack_out (ped_ack_out),
        .state_out   (state_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input logic [2:0] st,
                                 input logic ack);
        logic [2:0] ns_e;
        logic [2:0] ew_e;
        ns_e = 3'b100;
        ew_e = 3'b100;
        if (st == S_NSG) ns_e = 3'b001;
        if (st == S_NSY) ns_e = 3'b010;
        if (st == S_EWG) ew_e = 3'b001;
        if (st == S_EWY) ew_e = 3'b010;
        check("state", 32'(state_out), 32'(st));
        check("ns", 32'(ns_light), 32'(ns_e));
        check("ew", 32'(ew_light), 32'(ew_e));
        check("walk", 32'(walk_out), 32'(st == S_PED));
        check("ack", 32'(ped_ack_out), 32'(ack));
    endtask

    task automatic dwell(input logic [2:0] st, input int n);
        for (int i = 0; i < n; i++) begin
            check_outputs(st, (st == S_PED) && (i == 0));
            @(negedge clk_in);
        end
    endtask

    task automatic tick4_phase(input logic [2:0] st, input int n);
        for (int k = 0; k < n * 4; k++) begin
            check_outputs(st, 1'b0);
            tick_in = ((k % 4) == 3);
            @(negedge clk_in);
        end
    endtask

    always @(negedge clk_in) begin
        if (running)
            check("safety", 32'((ns_light == 3'b100) ||
                               (ew_light == 3'b100)), 32'd1);
    end

    initial begin
        @(negedge clk_in);
        check_outputs(S_AR, 1'b0);
        @(negedge clk_in);
        running = 1'b1;

        // 1: free-running ticks
        tick_in = 1'b1;
        rst_n = 1'b1;
        dwell(S_AR, 1);
        dwell(S_NSG, 10);
        dwell(S_NSY, 5);
        dwell(S_AR, 1);
        dwell(S_EWG, 10);
        dwell(S_EWY, 5);
        dwell(S_AR, 1);
        dwell(S_NSG, 10);
        dwell(S_NSY, 5);
        dwell(S_AR, 1);

        // 2: single pulse request during EW green
        ped_req_in = 1'b1;
        dwell(S_EWG, 1);
        ped_req_in = 1'b0;
        dwell(S_EWG, 9);
        dwell(S_EWY, 5);
        dwell(S_AR, 1);
        dwell(S_PED, 5);
        dwell(S_NSG, 10);
        dwell(S_NSY, 5);
        dwell(S_AR, 1);
        dwell(S_EWG, 1);

        // 3: request held high
        ped_req_in = 1'b1;
        dwell(S_EWG, 9);
        dwell(S_EWY, 5);
        dwell(S_AR, 1);
        dwell(S_PED, 5);
        dwell(S_NSG, 10);
        dwell(S_NSY, 5);
        dwell(S_AR, 1);
        dwell(S_PED, 5);
        ped_req_in = 1'b0;
        dwell(S_EWG, 10);
        dwell(S_EWY, 5);
        dwell(S_AR, 1);
        dwell(S_NSG, 1);

        // 4: one tick every 4 clocks from reset
        tick_in = 1'b0;
        rst_n = 1'b0;
        @(negedge clk_in);
        rst_n = 1'b1;
        tick4_phase(S_AR, 1);
        tick4_phase(S_NSG, 10);
        tick4_phase(S_NSY, 5);
        tick4_phase(S_AR, 1);
        tick4_phase(S_EWG, 2);

        // 5: async reset mid EW green with a pending request
        tick_in = 1'b0;
        ped_req_in = 1'b1;
        @(negedge clk_in);
        ped_req_in = 1'b0;
        check_outputs(S_EWG, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_outputs(S_AR, 1'b0);
        @(negedge clk_in);
        rst_n = 1'b1;
        tick_in = 1'b1;
        dwell(S_AR, 1);
        dwell(S_NSG, 10);
        dwell(S_NSY, 5);
        dwell(S_AR, 1);
        dwell(S_EWG, 3);

        // 6: illegal state deposit recovers to all-red
        tick_in = 1'b0;
        dut.state_q = 3'd6;
        #1 check("illegal_state", 32'(state_out), 32'd6);
        check("illegal_ns", 32'(ns_light), 32'h4);
        check("illegal_ew", 32'(ew_light), 32'h4);
        @(negedge clk_in);
        check_outputs(S_AR, 1'b0);
        tick_in = 1'b1;
        @(negedge clk_in);
        dwell(S_EWG, 2);

        running = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
